// File: rtl/truth_table_scanner_if.sv
// Signal bundle between the board-level controller (master) and the
// truth-table scanner (slave), including the function-block vector and y.
interface truth_table_scanner_if;
    logic        i_start;
    logic [15:0] i_expected;
    logic        i_y;
    logic        o_a;
    logic        o_b;
    logic        o_c;
    logic        o_d;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_table;
    logic        o_match;
    logic [3:0]  o_fail_index;

    modport master (
        output i_start, i_expected, i_y,
        input  o_a, o_b, o_c, o_d, o_busy, o_done, o_table, o_match, o_fail_index
    );

    modport slave (
        input  i_start, i_expected, i_y,
        output o_a, o_b, o_c, o_d, o_busy, o_done, o_table, o_match, o_fail_index
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Steps a 4-input function block through all 16 vectors, samples y after a
// programmable settle time, and compares the captured table to a latched expectation.
//
// state     | meaning
// ST_IDLE   | waiting for start, vector held at 0
// ST_WAIT   | vector driven, counting settle cycles
// ST_SAMPLE | capture y for the current vector
// ST_DONE   | result valid and held, start re-arms a scan
module truth_table_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input logic                  i_clk,
    input logic                  i_rst,
    truth_table_scanner_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;
    localparam logic [3:0] CNT_LAST  = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] table_q, table_d;
    logic        match_q, match_d;
    logic [3:0]  fail_idx_q, fail_idx_d;

    logic [15:0] final_table;
    logic [15:0] diff;
    logic [3:0]  first_diff;

    // Result is formed from the table including the bit captured this cycle.
    always_comb begin
        final_table = {bus.i_y, table_q[14:0]};
        diff        = final_table ^ exp_q;
        first_diff  = '0;
        for (int k = 15; k >= 0; k--) begin
            if (diff[k]) first_diff = 4'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        table_d    = table_q;
        match_d    = match_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_d    = ST_WAIT;
                    idx_d      = '0;
                    cnt_d      = '0;
                    table_d    = '0;
                    exp_d      = bus.i_expected;
                    match_d    = 1'b0;
                    fail_idx_d = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                table_d[idx_q] = bus.i_y;
                if (idx_q == 4'd15) begin
                    state_d    = ST_DONE;
                    match_d    = (final_table == exp_q);
                    fail_idx_d = first_diff;
                    idx_d      = '0;
                end else begin
                    state_d = ST_WAIT;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            match_q    <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            table_q    <= table_d;
            match_q    <= match_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign bus.o_a          = idx_q[3];
    assign bus.o_b          = idx_q[2];
    assign bus.o_c          = idx_q[1];
    assign bus.o_d          = idx_q[0];
    assign bus.o_busy       = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_table      = table_q;
    assign bus.o_match      = match_q;
    assign bus.o_fail_index = fail_idx_q;
endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequencer for the 4-input combinational function block (inputs a, b, c, d; output y). On a start request it drives all 16 input combinations in ascending binary order, waits a programmable settle time per vector, and captures y into a 16-bit truth-table register. At the end it compares the captured table against an expected table latched at start. It sits between the board-level control (buttons or the bench) and the function block, replacing hand-stepped stimulus with a self-checking scan.

## Interface
- SETTLE_CYCLES, 1: cycles each vector is held before y is sampled; legal range 1..15.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  scan request; accepted only in IDLE or DONE.
- i_expected  in  16  expected truth table, bit k = expected y for vector k; latched on start acceptance.
- i_y  in  1  output of the function block.
- o_a, o_b, o_c, o_d  out  1 each  vector to the function block; a = idx[3], b = idx[2], c = idx[1], d = idx[0].
- o_busy  out  1  high while a scan is in progress.
- o_done  out  1  high (level) in DONE until the next accepted start or reset.
- o_table  out  16  captured truth table, bit k = sampled y for vector k.
- o_match  out  1  valid when o_done = 1; 1 if o_table == latched expected.
- o_fail_index  out  4  valid when o_done = 1; lowest k with o_table[k] != expected[k]; 0 when o_match = 1.

## Operation
- Registers: state, idx[3:0], cnt[3:0], exp_q[15:0], o_table, o_match, o_fail_index.
- All outputs are registered or decoded directly from state/idx; no combinational path from i_y to any output.
- States and transitions:
  - IDLE: o_busy = 0, o_done = 0, idx = 0. On i_start: go to WAIT, idx <= 0, cnt <= 0, o_table <= 0, exp_q <= i_expected, o_match <= 0, o_fail_index <= 0.
  - WAIT: o_busy = 1. cnt increments each cycle. When cnt == SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: o_busy = 1. o_table[idx] <= i_y.
    - If idx == 15: go to DONE. o_match <= ({i_y, o_table[14:0]} == exp_q). o_fail_index <= lowest mismatch index of that same word (0 if none). idx <= 0.
    - Otherwise: idx <= idx + 1, cnt <= 0, go to WAIT.
  - DONE: o_busy = 0, o_done = 1. o_table, o_match and o_fail_index hold. On i_start: behave exactly as start in IDLE.
- o_a..o_d follow idx in every state, so they are 0 in IDLE and DONE.
- i_start is ignored in WAIT and SAMPLE. It is not queued.
- i_expected is don't-care except in the start-acceptance cycle.
- i_rst while busy abandons the scan; there is no partial result.

## Timing
- Reset (i_rst = 1 at clock edge): state = IDLE. o_a..o_d = 0, o_busy = 0, o_done = 0, o_table = 0, o_match = 0, o_fail_index = 0. Reset has priority over i_start.
- Start accepted at edge T0: o_busy = 1 and vector 0 is on o_a..o_d from T0+1.
- Each vector is held for SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in WAIT plus 1 in SAMPLE. y is sampled at the end of the SAMPLE cycle.
- Vector k is driven from T0 + 1 + k*(SETTLE_CYCLES+1).
- o_done rises and o_busy falls 16*(SETTLE_CYCLES+1) cycles after T0. For SETTLE_CYCLES = 1 this is 32 cycles.
- Vector transitions are single-step increments. 15 -> 0 happens only on entry to DONE.
- A start held high continuously in DONE retriggers a new scan on the cycle after DONE is entered. o_done is then high for exactly 1 cycle.

## Test plan
- Reset mid-scan: start, then assert i_rst at cycle 10 -> next cycle all outputs are 0 and state is IDLE; a later start performs a full 32-cycle scan.
- Passing scan: SETTLE_CYCLES = 1, model y = (a&b)|(c&d), i_expected = 16'hF888 -> o_busy for 32 cycles, then o_table = 16'hF888, o_match = 1, o_fail_index = 0; vectors seen in order 0..15, each held 2 cycles.
- Mismatch reporting: same model, i_expected = 16'h7889 -> o_match = 0, o_fail_index = 0. With i_expected = 16'h7888 -> o_fail_index = 15.
- Settle parameter: SETTLE_CYCLES = 3 with a model that delays y by 2 cycles -> o_table = 16'hF888 after 64 cycles. With SETTLE_CYCLES = 1 on the same model, the table is wrong and o_match = 0.
- Start rules: pulse i_start during the scan -> ignored, done still at 32 cycles. Change i_expected after acceptance -> the result uses the latched value. Hold i_start high through DONE -> o_done is high for 1 cycle, then a new scan starts and o_table clears.
